// File: rtl/ar_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ar_pkg
//  Brief    : Shared constants and state encoding for the byte-array write side
//  Revision : 1.0  initial release
// ============================================================================
package ar_pkg;

    localparam int ARRAY_SIZE = 8;
    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 3;
    localparam int INIT_VAL   = 10;
    localparam int CNT_MAX    = 255;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ar_w.sv
`default_nettype none
// ============================================================================
//  Module   : ar_w
//  Brief    : Write side of an 8-entry byte array. Fills every entry with a
//             default value after reset or clr, then accepts single-beat
//             writes over valid/ready. The whole array is exported flat.
//  Revision : 1.0  initial release
// ============================================================================
module ar_w
    import ar_pkg::*;
#(
    parameter int ARRAY_SIZE = ar_pkg::ARRAY_SIZE,
    parameter int DATA_W     = ar_pkg::DATA_W,
    parameter int ADDR_W     = ar_pkg::ADDR_W,
    parameter int INIT_VAL   = ar_pkg::INIT_VAL
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    output logic [ARRAY_SIZE*DATA_W-1:0] arr_flat,
    output logic                         busy,
    output logic [7:0]                   wr_cnt,
    output logic                         wr_err
);

    localparam int                 IDX_W      = $clog2(ARRAY_SIZE);
    localparam logic [IDX_W-1:0]   c_last_idx = IDX_W'(ARRAY_SIZE - 1);
    localparam logic [DATA_W-1:0]  c_init_val = DATA_W'(INIT_VAL);
    localparam logic [7:0]         c_cnt_max  = 8'(CNT_MAX);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [DATA_W-1:0]  r_mem [ARRAY_SIZE];
    logic [7:0]         r_cnt;
    logic               r_err;

    logic               w_accept;
    logic               w_addr_oob;
    logic [31:0]        w_addr_ext;
    logic [IDX_W-1:0]   w_wr_idx;

    // Address is widened so the range check also works when ADDR_W exceeds
    // the index width; the low bits select the entry when in range.
    assign w_addr_ext = 32'(wr_addr);
    assign w_addr_oob = (w_addr_ext >= 32'(ARRAY_SIZE));
    assign w_wr_idx   = wr_addr[IDX_W-1:0];
    assign w_accept   = wr_valid && wr_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; wr_ready never looks at wr_valid
    always_comb begin
        w_state_nxt = r_state;
        wr_ready    = 1'b0;
        busy        = 1'b0;
        case (r_state)
            INIT: begin
                busy = 1'b1;
                if (!clr && (r_idx == c_last_idx)) begin
                    w_state_nxt = READY;
                end
            end
            READY: begin
                wr_ready = !clr;
                if (clr) begin
                    w_state_nxt = INIT;
                end
            end
            default: begin
                w_state_nxt = INIT;
            end
        endcase
    end

    // Sweep index, storage, write counter and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
            for (int i = 0; i < ARRAY_SIZE; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (r_state == INIT) begin
                if (clr) begin
                    r_idx <= '0;
                end else begin
                    r_mem[r_idx] <= c_init_val;
                    r_idx        <= (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;
                end
            end else if (clr) begin
                r_idx <= '0;
            end

            if (w_accept) begin
                if (w_addr_oob) begin
                    r_err <= 1'b1;
                end else begin
                    r_mem[w_wr_idx] <= wr_data;
                end
            end

            if (clr) begin
                r_cnt <= '0;
            end else if (w_accept && (r_cnt != c_cnt_max)) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_flat
            assign arr_flat[gi*DATA_W +: DATA_W] = r_mem[gi];
        end
    endgenerate

    assign wr_cnt = r_cnt;
    assign wr_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ar_w.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ar_w
//  Brief    : Self-checking bench for ar_w (scoreboard of expected array/count)
//  Revision : 1.0  initial release
// ============================================================================
module tb_ar_w;
    import ar_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default-configuration instance
    logic        rst, clr, wr_valid;
    logic        wr_ready, busy, wr_err;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [63:0] arr_flat;
    logic [7:0]  wr_cnt;

    // Wide-address instance for the out-of-range case
    logic        rst_4, clr_4, wr_valid_4;
    logic        wr_ready_4, busy_4, wr_err_4;
    logic [3:0]  wr_addr_4;
    logic [7:0]  wr_data_4;
    logic [63:0] arr_flat_4;
    logic [7:0]  wr_cnt_4;

    ar_w dut (
        .clk(clk), .rst(rst), .clr(clr), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .arr_flat(arr_flat), .busy(busy),
        .wr_cnt(wr_cnt), .wr_err(wr_err)
    );

    ar_w #(.ADDR_W(4)) dut4 (
        .clk(clk), .rst(rst_4), .clr(clr_4), .wr_valid(wr_valid_4), .wr_ready(wr_ready_4),
        .wr_addr(wr_addr_4), .wr_data(wr_data_4), .arr_flat(arr_flat_4), .busy(busy_4),
        .wr_cnt(wr_cnt_4), .wr_err(wr_err_4)
    );

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] ALL_INIT = {8{8'd10}};

    // Reference model
    logic [7:0] m_mem [8];
    logic [7:0] m_cnt;
    logic       m_ready;

    typedef struct packed {
        logic [63:0] flat;
        logic [7:0]  cnt;
    } exp_t;
    exp_t sb[$];

    function automatic logic [63:0] m_flat();
        logic [63:0] f;
        for (int i = 0; i < 8; i++) f[i*8 +: 8] = m_mem[i];
        return f;
    endfunction

    task automatic m_sweep_done();
        for (int i = 0; i < 8; i++) m_mem[i] = 8'd10;
        m_cnt   = 8'd0;
        m_ready = 1'b1;
    endtask

    // Drive one cycle of stimulus; predicted result is queued when accepted
    task automatic drive_beat(input logic v, input logic [2:0] a, input logic [7:0] d);
        exp_t e;
        wr_valid = v;
        wr_addr  = a;
        wr_data  = d;
        if (v && m_ready) begin
            m_mem[a] = d;
            if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
            e.flat = m_flat();
            e.cnt  = m_cnt;
            sb.push_back(e);
        end
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b want 1", busy); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", wr_ready); end
        checks++; if (arr_flat !== 64'd0) begin errors++; $display("FAIL rst_flat got %h want 0", arr_flat); end
        checks++; if (wr_cnt !== 8'd0) begin errors++; $display("FAIL rst_cnt got %0d want 0", wr_cnt); end
        checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", wr_err); end
        rst = 1'b0;
        m_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (busy !== 1'b1 || wr_ready !== 1'b0) begin
                errors++; $display("FAIL sweep_flags cyc %0d busy %b ready %b want 1 0", k, busy, wr_ready);
            end
            @(negedge clk);
            checks++;
            if (arr_flat[k*8 +: 8] !== 8'd10) begin
                errors++; $display("FAIL sweep_entry %0d got %0d want 10", k, arr_flat[k*8 +: 8]);
            end
            if (k < 7) begin
                checks++;
                if (arr_flat[(k+1)*8 +: 8] !== 8'd0) begin
                    errors++; $display("FAIL sweep_order entry %0d got %0d want 0", k+1, arr_flat[(k+1)*8 +: 8]);
                end
            end
        end
        checks++; if (busy !== 1'b0 || wr_ready !== 1'b1) begin errors++; $display("FAIL ready_cyc8 busy %b ready %b want 0 1", busy, wr_ready); end
        checks++; if (arr_flat !== ALL_INIT) begin errors++; $display("FAIL init_flat got %h want %h", arr_flat, ALL_INIT); end
        m_sweep_done();
    endtask

    task automatic test_write_during_init();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_ready = 1'b0;
        wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (wr_ready !== 1'b0) begin errors++; $display("FAIL init_ready cyc %0d got %b want 0", k, wr_ready); end
            @(negedge clk);
        end
        wr_valid = 1'b0;
        @(negedge clk);
        checks++; if (arr_flat[7:0] !== 8'd10) begin errors++; $display("FAIL init_ignore entry0 got %h want 0a", arr_flat[7:0]); end
        checks++; if (wr_cnt !== 8'd0) begin errors++; $display("FAIL init_ignore cnt got %0d want 0", wr_cnt); end
        m_sweep_done();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        drive_beat(1'b1, 3'd3, 8'hA5);
        e = sb.pop_front();
        checks++; if (arr_flat !== e.flat || wr_cnt !== e.cnt) begin errors++; $display("FAIL b2b_first got %h/%0d want %h/%0d", arr_flat, wr_cnt, e.flat, e.cnt); end
        drive_beat(1'b1, 3'd3, 8'h5A);
        e = sb.pop_front();
        checks++; if (arr_flat !== e.flat || wr_cnt !== e.cnt) begin errors++; $display("FAIL b2b_second got %h/%0d want %h/%0d", arr_flat, wr_cnt, e.flat, e.cnt); end
        checks++; if (wr_cnt !== 8'd2) begin errors++; $display("FAIL b2b_cnt got %0d want 2", wr_cnt); end
    endtask

    task automatic test_clr();
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            drive_beat(1'b1, 3'(i), 8'((i + 1) * 17));
            e = sb.pop_front();
            checks++; if (arr_flat !== e.flat || wr_cnt !== e.cnt) begin errors++; $display("FAIL fill %0d got %h/%0d want %h/%0d", i, arr_flat, wr_cnt, e.flat, e.cnt); end
        end
        clr = 1'b1; wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 8'hEE;
        #1;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL clr_ready got %b want 0", wr_ready); end
        @(negedge clk);
        clr = 1'b0; wr_valid = 1'b0;
        m_ready = 1'b0;
        checks++; if (busy !== 1'b1 || wr_cnt !== 8'd0) begin errors++; $display("FAIL clr_next busy %b cnt %0d want 1 0", busy, wr_cnt); end
        checks++; if (arr_flat[7:0] !== 8'h11) begin errors++; $display("FAIL clr_noaccept entry0 got %h want 11", arr_flat[7:0]); end
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy cyc n+%0d got %b want 1", k, busy); end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || wr_ready !== 1'b1) begin errors++; $display("FAIL clr_done busy %b ready %b want 0 1", busy, wr_ready); end
        checks++; if (arr_flat !== ALL_INIT || wr_cnt !== 8'd0) begin errors++; $display("FAIL clr_flat got %h/%0d want %h/0", arr_flat, wr_cnt, ALL_INIT); end
        m_sweep_done();
    endtask

    task automatic test_rst_mid_sweep();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_ready = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (arr_flat[31:0] !== {4{8'd10}}) begin errors++; $display("FAIL mid_pre got %h want 0a0a0a0a", arr_flat[31:0]); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (arr_flat !== 64'd0 || busy !== 1'b1) begin errors++; $display("FAIL mid_rst flat %h busy %b want 0 1", arr_flat, busy); end
        @(negedge clk);
        checks++; if (arr_flat[15:0] !== 16'h000A) begin errors++; $display("FAIL mid_restart got %h want 000a", arr_flat[15:0]); end
        repeat (7) @(negedge clk);
        checks++; if (wr_ready !== 1'b1 || arr_flat !== ALL_INIT) begin errors++; $display("FAIL mid_done ready %b flat %h", wr_ready, arr_flat); end
        m_sweep_done();
    endtask

    task automatic test_saturate();
        exp_t e;
        for (int i = 0; i < 300; i++) begin
            drive_beat(1'b1, 3'(i % 8), 8'(i));
            if (sb.size() == 0) begin
                checks++; errors++; $display("FAIL sat_sb_empty beat %0d", i);
            end else begin
                e = sb.pop_front();
                checks++;
                if (arr_flat !== e.flat || wr_cnt !== e.cnt) begin
                    errors++; $display("FAIL sat beat %0d got %h/%0d want %h/%0d", i, arr_flat, wr_cnt, e.flat, e.cnt);
                end
            end
        end
        checks++; if (wr_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt got %0d want 255", wr_cnt); end
        checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL sat_err got %b want 0", wr_err); end
    endtask

    task automatic test_oob();
        rst_4 = 1'b1;
        @(negedge clk);
        rst_4 = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (wr_ready_4 !== 1'b1) begin errors++; $display("FAIL oob_ready got %b want 1", wr_ready_4); end
        wr_valid_4 = 1'b1; wr_addr_4 = 4'd12; wr_data_4 = 8'h77;
        @(negedge clk);
        wr_valid_4 = 1'b0;
        checks++; if (wr_err_4 !== 1'b1) begin errors++; $display("FAIL oob_err got %b want 1", wr_err_4); end
        checks++; if (arr_flat_4 !== ALL_INIT || wr_cnt_4 !== 8'd1) begin errors++; $display("FAIL oob_flat got %h/%0d want %h/1", arr_flat_4, wr_cnt_4, ALL_INIT); end
        wr_valid_4 = 1'b1; wr_addr_4 = 4'd2; wr_data_4 = 8'h33;
        @(negedge clk);
        wr_valid_4 = 1'b0;
        checks++; if (arr_flat_4[23:16] !== 8'h33 || wr_err_4 !== 1'b1) begin errors++; $display("FAIL oob_inrange entry2 %h err %b want 33 1", arr_flat_4[23:16], wr_err_4); end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rst_4 = 1'b1; clr_4 = 1'b0; wr_valid_4 = 1'b0; wr_addr_4 = '0; wr_data_4 = '0;
        m_ready = 1'b0; m_cnt = 8'd0;
        for (int i = 0; i < 8; i++) m_mem[i] = 8'd0;
        test_reset();
        test_back_to_back();
        test_write_during_init();
        test_clr();
        test_rst_mid_sweep();
        test_saturate();
        test_oob();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
